alu_issue_ctrl: RTL and testbench

//   Initiator side of the ALU operand/control interface (ALUCtrl, BusA, BusB -> BusW, Zero).

---
 rtl/alu_issue_ctrl_if.sv | 42 ++++
 rtl/alu_issue_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Signal bundle between alu_issue_ctrl and its surroundings: the decode-side
// instruction handshake, the ALU operand/result bus and the writeback-side
// result handshake. The master modport is the issue controller; the slave
// modport is the environment (decode stage, ALU and writeback stage).
interface alu_issue_ctrl_if;
  // decode -> controller
  logic        InValid;
  logic        InReady;
  logic [5:0]  Opcode;
  logic [5:0]  Funct;
  logic [4:0]  Shamt;
  logic [15:0] Imm16;
  logic [31:0] RsData;
  logic [31:0] RtData;
  // controller <-> ALU
  logic [3:0]  ALUCtrl;
  logic [31:0] BusA;
  logic [31:0] BusB;
  logic [31:0] BusW;
  logic        Zero;
  // controller -> writeback
  logic        OutValid;
  logic        OutReady;
  logic [31:0] Result;
  logic        ZeroOut;
  logic        Illegal;
  logic        Overflow;

  modport master (
    input  InValid, Opcode, Funct, Shamt, Imm16, RsData, RtData,
    input  BusW, Zero, OutReady,
    output InReady, ALUCtrl, BusA, BusB,
    output OutValid, Result, ZeroOut, Illegal, Overflow
  );

  modport slave (
    output InValid, Opcode, Funct, Shamt, Imm16, RsData, RtData,
    output BusW, Zero, OutReady,
    input  InReady, ALUCtrl, BusA, BusB,
    input  OutValid, Result, ZeroOut, Illegal, Overflow
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts one decoded MIPS instruction, drives ALUCtrl and the
// BusA/BusB operands, waits ALU_LAT cycles for the ALU to settle, captures
// BusW/Zero and hands the result downstream on a valid/ready handshake.
// Optional feature macro: ALU_OVF_TRAP_EN (signed overflow flag for ADD/ADDI/SUB).
module alu_issue_ctrl #(
  parameter int ALU_LAT = 3
) (
  input logic              CLK,
  input logic              Reset,
  alu_issue_ctrl_if.master bus
);

  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0]  ctrl_q;
  logic [31:0] a_q, b_q;
  logic [31:0] result_q;
  logic        zero_q;
  logic        illegal_q;

  logic [3:0]  dec_ctrl;
  logic [31:0] dec_a, dec_b;
  logic        dec_illegal;
  logic [31:0] imm_sext, imm_zext;
  logic        accept, capture;

  assign imm_sext = {{16{bus.Imm16[15]}}, bus.Imm16};
  assign imm_zext = {16'b0, bus.Imm16};
  assign accept   = (state_q == S_IDLE) && bus.InValid;
  assign capture  = (state_q == S_WAIT) && (cnt_q == '0);

  // Decode opcode/funct into the ALU control code and operand selection.
  always_comb begin
    dec_illegal = 1'b0;
    dec_ctrl    = 4'b0000;
    dec_a       = bus.RsData;
    dec_b       = bus.RtData;
    case (bus.Opcode)
      6'h00: begin
        case (bus.Funct)
          6'h20: dec_ctrl = 4'b0010;
          6'h21: dec_ctrl = 4'b1000;
          6'h22: dec_ctrl = 4'b0110;
          6'h23: dec_ctrl = 4'b1001;
          6'h24: dec_ctrl = 4'b0000;
          6'h25: dec_ctrl = 4'b0001;
          6'h26: dec_ctrl = 4'b1010;
          6'h27: dec_ctrl = 4'b1100;
          6'h2A: dec_ctrl = 4'b0111;
          6'h2B: dec_ctrl = 4'b1011;
          6'h00, 6'h02, 6'h03: begin
            // shifts take the value from rt and the amount from shamt
            dec_a = bus.RtData;
            dec_b = {27'b0, bus.Shamt};
            case (bus.Funct)
              6'h00:   dec_ctrl = 4'b0011;
              6'h02:   dec_ctrl = 4'b0100;
              default: dec_ctrl = 4'b1101;
            endcase
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      6'h08: begin dec_ctrl = 4'b0010; dec_b = imm_sext; end
      6'h09: begin dec_ctrl = 4'b1000; dec_b = imm_sext; end
      6'h0A: begin dec_ctrl = 4'b0111; dec_b = imm_sext; end
      6'h0B: begin dec_ctrl = 4'b1011; dec_b = imm_sext; end
      6'h0C: begin dec_ctrl = 4'b0000; dec_b = imm_zext; end
      6'h0D: begin dec_ctrl = 4'b0001; dec_b = imm_zext; end
      6'h0E: begin dec_ctrl = 4'b1010; dec_b = imm_zext; end
      6'h0F: begin dec_ctrl = 4'b1110; dec_b = imm_zext; end
      // branches compare rs and rt by subtraction; Zero carries the result
      6'h04, 6'h05: dec_ctrl = 4'b0110;
      default: dec_illegal = 1'b1;
    endcase
  end

  // State and settle-counter register.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: illegal ops skip the ALU wait entirely.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.InValid) begin
          if (dec_illegal) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(ALU_LAT - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_DONE: begin
        if (bus.OutReady) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand registers load on a legal accept; result registers load at capture.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      ctrl_q    <= 4'b0000;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      illegal_q <= dec_illegal;
      if (dec_illegal) begin
        result_q <= '0;
        zero_q   <= 1'b0;
      end else begin
        ctrl_q <= dec_ctrl;
        a_q    <= dec_a;
        b_q    <= dec_b;
      end
    end else if (capture) begin
      result_q <= bus.BusW;
      zero_q   <= bus.Zero;
    end
  end

`ifdef ALU_OVF_TRAP_EN
  logic is_add_q, is_sub_q, ovf_q;

  // Remember whether the issued op is a trapping add/sub, flag overflow at capture.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      is_add_q <= 1'b0;
      is_sub_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      is_add_q <= ~dec_illegal && ((bus.Opcode == 6'h08) ||
                                   ((bus.Opcode == 6'h00) && (bus.Funct == 6'h20)));
      is_sub_q <= ~dec_illegal && (bus.Opcode == 6'h00) && (bus.Funct == 6'h22);
      ovf_q    <= 1'b0;
    end else if (capture) begin
      ovf_q <= (is_add_q && (a_q[31] == b_q[31]) && (bus.BusW[31] != a_q[31])) ||
               (is_sub_q && (a_q[31] != b_q[31]) && (bus.BusW[31] != a_q[31]));
    end
  end

  assign bus.Overflow = ovf_q;
`else
  assign bus.Overflow = 1'b0;
`endif

  assign bus.InReady  = (state_q == S_IDLE);
  assign bus.OutValid = (state_q == S_DONE);
  assign bus.ALUCtrl  = ctrl_q;
  assign bus.BusA     = a_q;
  assign bus.BusB     = b_q;
  assign bus.Result   = result_q;
  assign bus.ZeroOut  = zero_q;
  assign bus.Illegal  = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl with a behavioural ALU attached to BusA/BusB.
// Vector table drives single instructions; a scoreboard queue holds the
// expected result of each accepted instruction until OutValid appears.
module tb_alu_issue_ctrl;

  localparam int ALU_LAT = 3;
`ifdef ALU_OVF_TRAP_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic Reset;

  alu_issue_ctrl_if bus_if ();

  alu_issue_ctrl #(.ALU_LAT(ALU_LAT)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus_if)
  );

  always #5 CLK = ~CLK;

  // Behavioural ALU driven by the controller's operand bus.
  always_comb begin
    case (bus_if.ALUCtrl)
      4'b0010, 4'b1000: bus_if.BusW = bus_if.BusA + bus_if.BusB;
      4'b0110, 4'b1001: bus_if.BusW = bus_if.BusA - bus_if.BusB;
      4'b0000: bus_if.BusW = bus_if.BusA & bus_if.BusB;
      4'b0001: bus_if.BusW = bus_if.BusA | bus_if.BusB;
      4'b1010: bus_if.BusW = bus_if.BusA ^ bus_if.BusB;
      4'b1100: bus_if.BusW = ~(bus_if.BusA | bus_if.BusB);
      4'b0111: bus_if.BusW = {31'b0, $signed(bus_if.BusA) < $signed(bus_if.BusB)};
      4'b1011: bus_if.BusW = {31'b0, bus_if.BusA < bus_if.BusB};
      4'b0011: bus_if.BusW = bus_if.BusA << bus_if.BusB[4:0];
      4'b0100: bus_if.BusW = bus_if.BusA >> bus_if.BusB[4:0];
      4'b1101: bus_if.BusW = $unsigned($signed(bus_if.BusA) >>> bus_if.BusB[4:0]);
      4'b1110: bus_if.BusW = bus_if.BusB << 16;
      default: bus_if.BusW = 32'h0;
    endcase
    bus_if.Zero = (bus_if.BusW == 32'h0);
  end

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  sh;
    logic [15:0] imm;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        ill;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        ill;
    logic        ovf;
  } exp_t;

  localparam int NV = 25;
  vec_t vecs [NV];
  exp_t sb [$];

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0]  last_ctrl = 4'b0000;
  logic [31:0] last_a = 32'h0;
  logic [31:0] last_b = 32'h0;

  function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                              input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt,
                              input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] res, input logic z, input logic ill, input logic ovf);
    vec_t v;
    v.op = op; v.fn = fn; v.sh = sh; v.imm = imm; v.rs = rs; v.rt = rt;
    v.ctrl = ctrl; v.a = a; v.b = b; v.res = res; v.z = z; v.ill = ill; v.ovf = ovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Issue one instruction; stall = cycles OutReady is held low once OutValid rises.
  task automatic run_vec(input vec_t v, input int idx, input int stall);
    exp_t e;
    int   n;
    @(negedge CLK);
    chk($sformatf("v%0d in_ready_idle", idx), {31'b0, bus_if.InReady}, 32'd1);
    bus_if.Opcode = v.op; bus_if.Funct = v.fn; bus_if.Shamt = v.sh; bus_if.Imm16 = v.imm;
    bus_if.RsData = v.rs; bus_if.RtData = v.rt;
    bus_if.InValid  = 1'b1;
    bus_if.OutReady = (stall == 0);
    @(posedge CLK);
    e.res = v.res; e.z = v.z; e.ill = v.ill; e.ovf = OVF_EN ? v.ovf : 1'b0;
    sb.push_back(e);
    @(negedge CLK);
    bus_if.InValid = 1'b0;
    if (!v.ill) begin
      last_ctrl = v.ctrl; last_a = v.a; last_b = v.b;
    end
    chk($sformatf("v%0d alu_ctrl", idx), {28'b0, bus_if.ALUCtrl}, {28'b0, last_ctrl});
    chk($sformatf("v%0d bus_a", idx), bus_if.BusA, last_a);
    chk($sformatf("v%0d bus_b", idx), bus_if.BusB, last_b);
    chk($sformatf("v%0d in_ready_busy", idx), {31'b0, bus_if.InReady}, 32'd0);
    n = 0;
    while (!bus_if.OutValid && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (!bus_if.OutValid) begin
      timeout_fail($sformatf("v%0d out_valid", idx));
      bus_if.OutReady = 1'b1;
      return;
    end
    chk($sformatf("v%0d latency", idx), n, v.ill ? 32'd0 : ALU_LAT);
    if (sb.size() == 0) begin
      timeout_fail($sformatf("v%0d scoreboard_empty", idx));
      return;
    end
    e = sb.pop_front();
    chk($sformatf("v%0d result", idx), bus_if.Result, e.res);
    chk($sformatf("v%0d zero_out", idx), {31'b0, bus_if.ZeroOut}, {31'b0, e.z});
    chk($sformatf("v%0d illegal", idx), {31'b0, bus_if.Illegal}, {31'b0, e.ill});
    chk($sformatf("v%0d overflow", idx), {31'b0, bus_if.Overflow}, {31'b0, e.ovf});
    // backpressure: output must hold and no new instruction may be taken
    for (int k = 0; k < stall; k++) begin
      bus_if.Opcode = 6'h0F; bus_if.Imm16 = 16'h5A5A; bus_if.InValid = 1'b1;
      @(negedge CLK);
      chk($sformatf("v%0d hold_valid%0d", idx, k), {31'b0, bus_if.OutValid}, 32'd1);
      chk($sformatf("v%0d hold_result%0d", idx, k), bus_if.Result, e.res);
      chk($sformatf("v%0d hold_ready%0d", idx, k), {31'b0, bus_if.InReady}, 32'd0);
      chk($sformatf("v%0d hold_ctrl%0d", idx, k), {28'b0, bus_if.ALUCtrl}, {28'b0, last_ctrl});
    end
    bus_if.InValid  = 1'b0;
    bus_if.OutReady = 1'b1;
    @(negedge CLK);
    chk($sformatf("v%0d out_valid_drop", idx), {31'b0, bus_if.OutValid}, 32'd0);
    chk($sformatf("v%0d in_ready_back", idx), {31'b0, bus_if.InReady}, 32'd1);
    $display("vec %0d op=%h fn=%h ctrl=%b A=%h B=%h result=%h zero=%0b illegal=%0b ovf=%0b",
             idx, v.op, v.fn, bus_if.ALUCtrl, bus_if.BusA, bus_if.BusB, e.res, e.z, e.ill, e.ovf);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //           op     fn     sh     imm       rs            rt            ctrl     A             B             result       z     ill   ovf
    vecs[0]  = mk(6'h00, 6'h20, 5'd0,  16'h0000, 32'd5,        32'd7,        4'b0010, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0, 1'b0);
    vecs[1]  = mk(6'h04, 6'h00, 5'd0,  16'h0000, 32'h1234,     32'h1234,     4'b0110, 32'h1234,     32'h1234,     32'h0,        1'b1, 1'b0, 1'b0);
    vecs[2]  = mk(6'h00, 6'h00, 5'd31, 16'h0000, 32'h55,       32'd1,        4'b0011, 32'd1,        32'd31,       32'h80000000, 1'b0, 1'b0, 1'b0);
    vecs[3]  = mk(6'h0F, 6'h00, 5'd0,  16'hABCD, 32'h11,       32'h0,        4'b1110, 32'h11,       32'h0000ABCD, 32'hABCD0000, 1'b0, 1'b0, 1'b0);
    vecs[4]  = mk(6'h0C, 6'h00, 5'd0,  16'h8000, 32'hFFFFFFFF, 32'h0,        4'b0000, 32'hFFFFFFFF, 32'h00008000, 32'h00008000, 1'b0, 1'b0, 1'b0);
    vecs[5]  = mk(6'h00, 6'h22, 5'd0,  16'h0000, 32'd3,        32'd3,        4'b0110, 32'd3,        32'd3,        32'h0,        1'b1, 1'b0, 1'b0);
    vecs[6]  = mk(6'h00, 6'h2A, 5'd0,  16'h0000, 32'hFFFFFFFF, 32'd1,        4'b0111, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0, 1'b0);
    vecs[7]  = mk(6'h00, 6'h2B, 5'd0,  16'h0000, 32'hFFFFFFFF, 32'd1,        4'b1011, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0, 1'b0);
    vecs[8]  = mk(6'h00, 6'h27, 5'd0,  16'h0000, 32'h0,        32'h0,        4'b1100, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    vecs[9]  = mk(6'h00, 6'h03, 5'd4,  16'h0000, 32'h0,        32'h80000000, 4'b1101, 32'h80000000, 32'd4,        32'hF8000000, 1'b0, 1'b0, 1'b0);
    vecs[10] = mk(6'h08, 6'h00, 5'd0,  16'h0001, 32'h7FFFFFFF, 32'h0,        4'b0010, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1'b0, 1'b1);
    vecs[11] = mk(6'h09, 6'h00, 5'd0,  16'h0001, 32'h7FFFFFFF, 32'h0,        4'b1000, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1'b0, 1'b0);
    vecs[12] = mk(6'h0A, 6'h00, 5'd0,  16'hFFFF, 32'd5,        32'h0,        4'b0111, 32'd5,        32'hFFFFFFFF, 32'd0,        1'b1, 1'b0, 1'b0);
    vecs[13] = mk(6'h0D, 6'h00, 5'd0,  16'h000F, 32'hF0,       32'h0,        4'b0001, 32'hF0,       32'hF,        32'hFF,       1'b0, 1'b0, 1'b0);
    vecs[14] = mk(6'h3F, 6'h00, 5'd0,  16'h1234, 32'h99,       32'h77,       4'b0000, 32'h0,        32'h0,        32'h0,        1'b0, 1'b1, 1'b0);
    vecs[15] = mk(6'h00, 6'h26, 5'd0,  16'h0000, 32'hFF,       32'h0F,       4'b1010, 32'hFF,       32'h0F,       32'hF0,       1'b0, 1'b0, 1'b0);
    vecs[16] = mk(6'h00, 6'h01, 5'd0,  16'h0000, 32'd1,        32'd2,        4'b0000, 32'h0,        32'h0,        32'h0,        1'b0, 1'b1, 1'b0);
    vecs[17] = mk(6'h00, 6'h22, 5'd0,  16'h0000, 32'h80000000, 32'd1,        4'b0110, 32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b0, 1'b0, 1'b1);
    vecs[18] = mk(6'h00, 6'h02, 5'd31, 16'h0000, 32'h0,        32'h80000000, 4'b0100, 32'h80000000, 32'd31,       32'd1,        1'b0, 1'b0, 1'b0);
    vecs[19] = mk(6'h05, 6'h00, 5'd0,  16'h0000, 32'd1,        32'd2,        4'b0110, 32'd1,        32'd2,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    vecs[20] = mk(6'h00, 6'h23, 5'd0,  16'h0000, 32'd0,        32'd1,        4'b1001, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    vecs[21] = mk(6'h00, 6'h21, 5'd0,  16'h0000, 32'hFFFFFFFF, 32'd1,        4'b1000, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0, 1'b0);
    vecs[22] = mk(6'h0E, 6'h00, 5'd0,  16'h8001, 32'hFFFF0000, 32'h0,        4'b1010, 32'hFFFF0000, 32'h00008001, 32'hFFFF8001, 1'b0, 1'b0, 1'b0);
    vecs[23] = mk(6'h0B, 6'h00, 5'd0,  16'hFFFF, 32'd1,        32'h0,        4'b1011, 32'd1,        32'hFFFFFFFF, 32'd1,        1'b0, 1'b0, 1'b0);
    vecs[24] = mk(6'h00, 6'h20, 5'd0,  16'h0000, 32'h7FFFFFFF, 32'h7FFFFFFF, 4'b0010, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1);

    Reset = 1'b1;
    bus_if.InValid = 1'b0; bus_if.OutReady = 1'b1;
    bus_if.Opcode = '0; bus_if.Funct = '0; bus_if.Shamt = '0; bus_if.Imm16 = '0;
    bus_if.RsData = '0; bus_if.RtData = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    Reset = 1'b0;

    // reset state
    chk("rst in_ready", {31'b0, bus_if.InReady}, 32'd1);
    chk("rst out_valid", {31'b0, bus_if.OutValid}, 32'd0);
    chk("rst result", bus_if.Result, 32'h0);
    chk("rst zero_out", {31'b0, bus_if.ZeroOut}, 32'd0);
    chk("rst illegal", {31'b0, bus_if.Illegal}, 32'd0);
    chk("rst overflow", {31'b0, bus_if.Overflow}, 32'd0);
    chk("rst alu_ctrl", {28'b0, bus_if.ALUCtrl}, 32'd0);
    chk("rst bus_a", bus_if.BusA, 32'h0);
    chk("rst bus_b", bus_if.BusB, 32'h0);

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i, 0);

    // backpressure: OutReady low for 5 cycles after the result appears
    run_vec(mk(6'h00, 6'h20, 5'd0, 16'h0, 32'd10, 32'd20, 4'b0010, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0, 1'b0), 100, 5);

    // reset while waiting on the ALU: operation is dropped
    @(negedge CLK);
    bus_if.Opcode = 6'h00; bus_if.Funct = 6'h25; bus_if.RsData = 32'hF000; bus_if.RtData = 32'h000F;
    bus_if.InValid = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    bus_if.InValid = 1'b0;
    chk("midrst in_ready_busy", {31'b0, bus_if.InReady}, 32'd0);
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    chk("midrst in_ready", {31'b0, bus_if.InReady}, 32'd1);
    chk("midrst out_valid", {31'b0, bus_if.OutValid}, 32'd0);
    chk("midrst alu_ctrl", {28'b0, bus_if.ALUCtrl}, 32'd0);
    last_ctrl = 4'b0000; last_a = 32'h0; last_b = 32'h0;
    for (int k = 0; k < ALU_LAT + 2; k++) begin
      @(negedge CLK);
      chk($sformatf("midrst no_result%0d", k), {31'b0, bus_if.OutValid}, 32'd0);
    end
    $display("midrst sequence: operation abandoned, controller idle");

    // recovery after the abandoned operation
    run_vec(vecs[0], 200, 0);

    chk("sb drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
